// File: rtl/transconv_requant_buffer.sv
// Requantises transconv accumulator pixels (rounding shift, optional ReLU, int8 saturation) and buffers them for raster output.
// Latency: 3 cycles from input accept to out_valid with an empty buffer (shift stage, clamp stage, output register).
// Backpressure: credit based, in_ready drops once buffered plus in-flight pixels reach DEPTH; outputs hold while out_ready is low.
module transconv_requant_buffer #(
   parameter int IN_W         = 20,
   parameter int OUT_W        = 8,
   parameter int IMAGE_WIDTH  = 8,
   parameter int IMAGE_HEIGHT = 8,
   parameter int DEPTH        = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [IN_W-1:0]  in_pixel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4:0]              shift,
   input  logic                    relu_en,
   output logic signed [OUT_W-1:0] out_pixel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last_col,
   output logic                    out_last_frame,
   output logic [15:0]             sat_count
);

   localparam int AW   = $clog2(DEPTH);
   localparam int OCW  = $clog2(DEPTH + 4) + 1;
   localparam int COLS = 2 * IMAGE_WIDTH;
   localparam int ROWS = 2 * IMAGE_HEIGHT;
   localparam int XW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int YW   = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic signed [IN_W:0] SAT_MAX = (IN_W + 1)'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;
   localparam logic [OUT_W-1:0]     PIX_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
   localparam logic [OUT_W-1:0]     PIX_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

   // control and input-side state
   logic                    r_started;
   logic [XW-1:0]           r_in_col;
   logic [YW-1:0]           r_in_row;
   logic [4:0]              r_cfg_shift;
   logic                    r_cfg_relu;

   // pipeline registers
   logic                    r_s1_vld;
   logic                    r_s1_relu;
   logic signed [IN_W:0]    r_s1_val;
   logic                    r_s2_vld;
   logic                    r_s2_sat;
   logic [OUT_W-1:0]        r_s2_pix;

   // buffer storage behind the output register
   logic [OUT_W-1:0]        r_mem [DEPTH];
   logic [AW-1:0]           r_wr_ptr;
   logic [AW-1:0]           r_rd_ptr;
   logic [AW:0]             r_mem_cnt;

   // output register and raster position
   logic                    r_out_vld;
   logic [OUT_W-1:0]        r_out_pix;
   logic                    r_out_last_col;
   logic                    r_out_last_frame;
   logic [XW-1:0]           r_out_col;
   logic [YW-1:0]           r_out_row;
   logic [15:0]             r_sat_cnt;

   logic                    w_accept;
   logic                    w_first;
   logic [OCW-1:0]          w_occ;
   logic [4:0]              w_shift;
   logic                    w_relu;
   logic signed [IN_W:0]    w_ext;
   logic signed [IN_W:0]    w_rnd;
   logic signed [IN_W:0]    w_sum;
   logic signed [IN_W:0]    w_shr;
   logic signed [IN_W:0]    w_relu_val;
   logic [OUT_W-1:0]        w_s2_pix;
   logic                    w_s2_sat;
   logic                    w_out_free;
   logic                    w_mem_pop;
   logic                    w_bypass;
   logic                    w_mem_push;
   logic                    w_load;
   logic [OUT_W-1:0]        w_load_pix;

   // Credits cover everything already accepted: buffered pixels, the output register and both pipeline stages.
   assign w_occ    = OCW'(r_mem_cnt) + OCW'(r_out_vld) + OCW'(r_s1_vld) + OCW'(r_s2_vld);
   assign in_ready = r_started && (w_occ < OCW'(DEPTH));
   assign w_accept = in_valid && in_ready;
   assign w_first  = w_accept && (r_in_col == '0) && (r_in_row == '0);

   // Output side: the output register is refilled from the buffer first; a fresh pixel bypasses only when the buffer is empty.
   assign w_out_free = !r_out_vld || out_ready;
   assign w_mem_pop  = w_out_free && (r_mem_cnt != '0);
   assign w_bypass   = w_out_free && (r_mem_cnt == '0) && r_s2_vld;
   assign w_mem_push = r_s2_vld && !w_bypass;
   assign w_load     = w_mem_pop || w_bypass;
   assign w_load_pix = w_mem_pop ? r_mem[r_rd_ptr] : r_s2_pix;

   assign out_valid      = r_out_vld;
   assign out_pixel      = r_out_pix;
   assign out_last_col   = r_out_last_col;
   assign out_last_frame = r_out_last_frame;
   assign sat_count      = r_sat_cnt;

   // Stage 1 datapath: round-half-up arithmetic shift, config taken live on a frame's first pixel
   always_comb begin
      w_shift = w_first ? shift : r_cfg_shift;
      w_relu  = w_first ? relu_en : r_cfg_relu;
      w_ext   = {in_pixel[IN_W-1], in_pixel};
      w_rnd   = '0;
      if (w_shift != 5'd0) begin
         w_rnd = (IN_W + 1)'(1) << (w_shift - 5'd1);
      end
      w_sum   = w_ext + w_rnd;
      w_shr   = w_sum >>> w_shift;
   end

   // Stage 2 datapath: ReLU then clamp to the output range; only clamping raises the saturation flag
   always_comb begin
      w_relu_val = r_s1_val;
      if (r_s1_relu && (r_s1_val < 0)) begin
         w_relu_val = '0;
      end
      w_s2_sat = 1'b0;
      w_s2_pix = w_relu_val[OUT_W-1:0];
      if (w_relu_val > SAT_MAX) begin
         w_s2_pix = PIX_MAX;
         w_s2_sat = 1'b1;
      end else if (w_relu_val < SAT_MIN) begin
         w_s2_pix = PIX_MIN;
         w_s2_sat = 1'b1;
      end
   end

   // Hold in_ready low for the first cycle after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_started <= 1'b0;
      end else begin
         r_started <= 1'b1;
      end
   end

   // Input raster position and per-frame configuration latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_col    <= '0;
         r_in_row    <= '0;
         r_cfg_shift <= '0;
         r_cfg_relu  <= 1'b0;
      end else if (w_accept) begin
         if (r_in_col == XW'(COLS - 1)) begin
            r_in_col <= '0;
            r_in_row <= (r_in_row == YW'(ROWS - 1)) ? '0 : r_in_row + 1'b1;
         end else begin
            r_in_col <= r_in_col + 1'b1;
         end
         if (w_first) begin
            r_cfg_shift <= shift;
            r_cfg_relu  <= relu_en;
         end
      end
   end

   // Two-stage pipeline registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld  <= 1'b0;
         r_s1_relu <= 1'b0;
         r_s1_val  <= '0;
         r_s2_vld  <= 1'b0;
         r_s2_sat  <= 1'b0;
         r_s2_pix  <= '0;
      end else begin
         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_s1_val  <= w_shr;
            r_s1_relu <= w_relu;
         end
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_pix <= w_s2_pix;
            r_s2_sat <= w_s2_sat;
         end
      end
   end

   // Buffer storage write port; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (w_mem_push) begin
         r_mem[r_wr_ptr] <= r_s2_pix;
      end
   end

   // Buffer pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_mem_cnt <= '0;
      end else begin
         if (w_mem_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_mem_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_mem_push && !w_mem_pop) begin
            r_mem_cnt <= r_mem_cnt + 1'b1;
         end else if (!w_mem_push && w_mem_pop) begin
            r_mem_cnt <= r_mem_cnt - 1'b1;
         end
      end
   end

   // Output register with raster markers; position advances each time a pixel is presented
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_vld        <= 1'b0;
         r_out_pix        <= '0;
         r_out_last_col   <= 1'b0;
         r_out_last_frame <= 1'b0;
         r_out_col        <= '0;
         r_out_row        <= '0;
      end else if (w_load) begin
         r_out_vld        <= 1'b1;
         r_out_pix        <= w_load_pix;
         r_out_last_col   <= (r_out_col == XW'(COLS - 1));
         r_out_last_frame <= (r_out_col == XW'(COLS - 1)) && (r_out_row == YW'(ROWS - 1));
         if (r_out_col == XW'(COLS - 1)) begin
            r_out_col <= '0;
            r_out_row <= (r_out_row == YW'(ROWS - 1)) ? '0 : r_out_row + 1'b1;
         end else begin
            r_out_col <= r_out_col + 1'b1;
         end
      end else if (w_out_free) begin
         r_out_vld <= 1'b0;
      end
   end

   // Per-frame saturation counter: cleared by a frame's first accepted pixel, sticky at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sat_cnt <= '0;
      end else if (w_first) begin
         r_sat_cnt <= '0;
      end else if (r_s2_vld && r_s2_sat && (r_sat_cnt != 16'hFFFF)) begin
         r_sat_cnt <= r_sat_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_transconv_requant_buffer.sv
// Scoreboard bench for transconv_requant_buffer: expected pixels are queued at input accept and compared at output pop.
// Latency: the model is untimed; only the first-pixel latency probe looks at cycle timing.
// Backpressure: out_ready is driven directly or randomly; input waits on in_ready with a bounded cycle budget.
module tb_transconv_requant_buffer;

   localparam int COLS = 16;
   localparam int ROWS = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic signed [19:0] in_pixel = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [4:0]        shift = 5'd0;
   logic              relu_en = 1'b0;
   logic signed [7:0] out_pixel;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic              out_last_col;
   logic              out_last_frame;
   logic [15:0]       sat_count;

   int n_checks = 0;
   int n_fail   = 0;

   int q[$];
   int m_icol = 0, m_irow = 0, m_shift = 0, m_sat = 0;
   bit m_relu = 1'b0;
   int m_ocol = 0, m_orow = 0;
   int pops = 0, n_lc = 0, n_lf = 0;
   int e;

   transconv_requant_buffer #(
      .IN_W(20), .OUT_W(8), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .DEPTH(16)
   ) dut (
      .clk(clk), .rst(rst),
      .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
      .shift(shift), .relu_en(relu_en),
      .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
      .out_last_col(out_last_col), .out_last_frame(out_last_frame),
      .sat_count(sat_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int requant(input int x, input int sh, input bit relu, output bit sat);
      int r;
      sat = 1'b0;
      if (sh == 0) r = x;
      else r = (x + (1 << (sh - 1))) >>> sh;
      if (relu && r < 0) r = 0;
      if (r > 127) begin r = 127; sat = 1'b1; end
      else if (r < -128) begin r = -128; sat = 1'b1; end
      return r;
   endfunction

   task automatic model_accept(input int x, input int exp, input bit use_exp);
      int r;
      bit s;
      if (m_icol == 0 && m_irow == 0) begin
         m_shift = int'(shift);
         m_relu  = relu_en;
         m_sat   = 0;
      end
      r = requant(x, m_shift, m_relu, s);
      if (s && m_sat < 65535) m_sat++;
      q.push_back(use_exp ? exp : r);
      if (m_icol == COLS - 1) begin
         m_icol = 0;
         m_irow = (m_irow == ROWS - 1) ? 0 : m_irow + 1;
      end else begin
         m_icol++;
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input int x, input int exp, input bit use_exp);
      int n;
      n = 0;
      in_pixel = 20'(x);
      in_valid = 1'b1;
      while (!in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("send_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      model_accept(x, exp, use_exp);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_m(input int x);
      send(x, 0, 1'b0);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", int'(n < 2000), 1);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pixel", out_pixel, 0);
      chk("rst_last_col", out_last_col, 0);
      chk("rst_last_frame", out_last_frame, 0);
      chk("rst_sat_count", sat_count, 0);
      chk("rst_in_ready", in_ready, 0);
      q.delete();
      m_icol = 0; m_irow = 0; m_ocol = 0; m_orow = 0; m_sat = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_release_in_ready", in_ready, 0);
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
   endtask

   function automatic int rnd_pix();
      return int'($urandom_range(0, 1048575)) - 524288;
   endfunction

   // Output monitor: compare each popped pixel and its raster markers against the scoreboard
   always begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("pop_unexpected", 1, 0);
         end else begin
            e = q.pop_front();
            chk("pix", out_pixel, e);
            chk("last_col", out_last_col, int'(m_ocol == COLS - 1));
            chk("last_frame", out_last_frame, int'(m_ocol == COLS - 1 && m_orow == ROWS - 1));
            if (out_last_col) n_lc++;
            if (out_last_frame) n_lf++;
            if (m_ocol == COLS - 1) begin
               m_ocol = 0;
               m_orow = (m_orow == ROWS - 1) ? 0 : m_orow + 1;
            end else begin
               m_ocol++;
            end
         end
         pops++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc, p0, lc0, lf0;
      @(negedge clk);

      // basic rounding with first-pixel latency probe
      do_reset();
      shift = 5'd4; relu_en = 1'b0; out_ready = 1'b1;
      send(1000, 63, 1'b1);
      chk("lat_cycle1", out_valid, 0);
      @(negedge clk);
      chk("lat_cycle2", out_valid, 0);
      @(negedge clk);
      chk("lat_cycle3", out_valid, 1);
      send(-1000, -62, 1'b1);
      send(8, 1, 1'b1);
      send(-9, -1, 1'b1);
      wait_drain();
      chk("basic_sat", sat_count, 0);

      // saturation both ways, then ReLU zeroing which is not saturation
      do_reset();
      shift = 5'd4; relu_en = 1'b0;
      send(5000, 127, 1'b1);
      send(-5000, -128, 1'b1);
      wait_drain();
      chk("sat_two", sat_count, 2);
      do_reset();
      shift = 5'd4; relu_en = 1'b1;
      send(-5000, 0, 1'b1);
      wait_drain();
      chk("relu_no_sat", sat_count, 0);

      // zero shift passes values through with clamping
      do_reset();
      shift = 5'd0; relu_en = 1'b0;
      send(100, 100, 1'b1);
      send(-100, -100, 1'b1);
      send(127, 127, 1'b1);
      send(128, 127, 1'b1);
      wait_drain();
      chk("shift0_sat", sat_count, 1);

      // full frame with random data, then the start of the next frame
      do_reset();
      shift = 5'd6; relu_en = 1'b0; out_ready = 1'b1;
      p0 = pops; lc0 = n_lc; lf0 = n_lf;
      for (int i = 0; i < COLS * ROWS; i++) send_m(rnd_pix());
      wait_drain();
      chk("ff_pops", pops - p0, 256);
      chk("ff_last_col_count", n_lc - lc0, 16);
      chk("ff_last_frame_count", n_lf - lf0, 1);
      chk("ff_sat", sat_count, m_sat);
      for (int i = 0; i < 3; i++) send_m(rnd_pix());
      wait_drain();
      chk("nf_last_col_count", n_lc - lc0, 16);
      chk("nf_sat", sat_count, m_sat);

      // backpressure: credits stop input at DEPTH, head holds, drain keeps order
      do_reset();
      shift = 5'd4; relu_en = 1'b0; out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         in_pixel = 20'(i * 16 + 3);
         in_valid = 1'b1;
         if (in_ready) begin
            model_accept(i * 16 + 3, 0, 1'b0);
            acc++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("bp_accepted", acc, 16);
      chk("bp_in_ready_low", in_ready, 0);
      repeat (3) @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_head", out_pixel, 0);
      repeat (4) @(negedge clk);
      chk("bp_hold", out_pixel, 0);
      chk("bp_still_full", in_ready, 0);
      p0 = pops;
      out_ready = 1'b1;
      wait_drain();
      chk("bp_drained", pops - p0, 16);

      // mid-frame shift change under random backpressure
      do_reset();
      shift = 5'd4; relu_en = 1'b0;
      fork
         begin
            for (int i = 0; i < 100; i++) send_m(int'($urandom_range(0, 6000)) - 3000);
            shift = 5'd2;
            for (int i = 0; i < 155; i++) send_m(int'($urandom_range(0, 6000)) - 3000);
            send(100, 6, 1'b1);
         end
         begin
            repeat (400) begin
               @(negedge clk);
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      wait_drain();
      chk("mid_sat", sat_count, m_sat);
      send(100, 25, 1'b1);
      wait_drain();

      // reset with pixels buffered
      do_reset();
      shift = 5'd4; relu_en = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_m(5000);
      repeat (4) @(negedge clk);
      chk("pre_rst_valid", out_valid, 1);
      chk("pre_rst_sat", sat_count, 5);
      do_reset();
      out_ready = 1'b1;
      send(5000, 127, 1'b1);
      chk("post_rst_sat_clear", sat_count, 0);
      p0 = pops; lc0 = n_lc;
      for (int i = 0; i < 15; i++) send_m(16 * i);
      wait_drain();
      chk("post_rst_pops", pops - p0, 16);
      chk("post_rst_row_end", n_lc - lc0, 1);
      chk("post_rst_sat", sat_count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
